conv_layer_sequencer: RTL

//  Initiator side of the convolution controller's control/init/finish/status handshake. Runs one layer
//  as NUM passes, one per input-channel group, and starts each pass by raising control.

---
 rtl/conv_layer_sequencer_pkg.sv | 23 ++
 rtl/conv_layer_sequencer_if.sv | 11 +
 rtl/conv_layer_sequencer_watchdog.sv | 34 +++
 rtl/conv_layer_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer: state encoding,
// control-word constants and the default watchdog limit.
package conv_seq_pkg;

  localparam logic [31:0] CTRL_GO     = 32'd1;
  localparam logic [31:0] CTRL_IDLE   = 32'd0;
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_STS,
    S_RELEASE,
    S_WAIT_CLR,
    S_DONE
  } seq_state_e;

  // The two states in which the sequencer is waiting on the controller.
  function automatic logic is_wait_state(seq_state_e s);
    return (s == S_WAIT_STS) || (s == S_WAIT_CLR);
  endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// Control/init/finish/status handshake between the layer sequencer (master)
// and the convolution controller (slave).
interface conv_layer_sequencer_if;
  logic [31:0] control;
  logic [31:0] init;
  logic [31:0] finish;
  logic [31:0] status;

  modport master (output control, output init, output finish, input status);
  modport slave  (input control, input init, input finish, output status);
endinterface

// File: rtl/conv_layer_sequencer_watchdog.sv
// Down-counting watchdog: reloaded on clear, counts while enabled, and
// reports expiry once the count has reached zero in an enabled state.
module seq_watchdog #(
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TIMEOUT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Reload has priority so a state change into another wait state restarts the budget.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = TIMEOUT;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer sequencer: runs num_passes control/status handshakes with the
// convolution controller, flagging init on the first pass and finish on the
// last. All outputs come straight from flops.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for start
//   S_ASSERT   | one cycle; raises control with init/finish for this pass
//   S_WAIT_STS | control held, waiting for status[0]=1 (watchdog running)
//   S_RELEASE  | one cycle; drops control/init/finish
//   S_WAIT_CLR | waiting for status[0]=0 before next pass (watchdog running)
//   S_DONE     | one cycle; produces the done pulse
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int               PASS_W  = 8,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [PASS_W-1:0]     num_passes_i,
  input  logic                  abort_i,
  conv_layer_sequencer_if.master ctrl,
  output logic [PASS_W-1:0]     pass_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  seq_state_e        state_q, state_d;
  logic [PASS_W-1:0] n_q, n_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic              abort_flag_q, abort_flag_d;
  logic              control_q, control_d;
  logic              init_q, init_d;
  logic              finish_q, finish_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              last_pass;
  logic              wd_clear, wd_enable, wd_expired;
  logic              unused_status;

  assign last_pass = (pass_idx_q == (n_q - PASS_W'(1)));
  assign wd_clear  = is_wait_state(state_d) && (state_d != state_q);
  assign wd_enable = is_wait_state(state_q);

  seq_watchdog #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // Next-state and next-output logic; outputs change on the edge that leaves a state.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    pass_idx_d   = pass_idx_q;
    abort_flag_d = abort_flag_q;
    control_d    = control_q;
    init_d       = init_q;
    finish_d     = finish_q;
    error_d      = error_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          error_d      = 1'b0;
          abort_flag_d = 1'b0;
          pass_idx_d   = '0;
          if (num_passes_i != '0) begin
            n_d     = num_passes_i;
            state_d = S_ASSERT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ASSERT: begin
        if (abort_i) begin
          control_d    = 1'b0;
          init_d       = 1'b0;
          finish_d     = 1'b0;
          error_d      = 1'b1;
          abort_flag_d = 1'b1;
          state_d      = S_WAIT_CLR;
        end else begin
          control_d = 1'b1;
          init_d    = (pass_idx_q == '0);
          finish_d  = last_pass;
          state_d   = S_WAIT_STS;
        end
      end
      S_WAIT_STS: begin
        if (abort_i) begin
          control_d    = 1'b0;
          init_d       = 1'b0;
          finish_d     = 1'b0;
          error_d      = 1'b1;
          abort_flag_d = 1'b1;
          state_d      = S_WAIT_CLR;
        end else if (ctrl.status[0]) begin
          state_d = S_RELEASE;
        end else if (wd_expired) begin
          control_d = 1'b0;
          init_d    = 1'b0;
          finish_d  = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RELEASE: begin
        control_d = 1'b0;
        init_d    = 1'b0;
        finish_d  = 1'b0;
        state_d   = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!ctrl.status[0]) begin
          if (abort_flag_q) begin
            state_d = S_IDLE;
          end else if (last_pass) begin
            state_d = S_DONE;
          end else begin
            pass_idx_d = pass_idx_q + PASS_W'(1);
            state_d    = S_ASSERT;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      pass_idx_q   <= '0;
      abort_flag_q <= 1'b0;
      control_q    <= 1'b0;
      init_q       <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      pass_idx_q   <= pass_idx_d;
      abort_flag_q <= abort_flag_d;
      control_q    <= control_d;
      init_q       <= init_d;
      finish_q     <= finish_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign ctrl.control = control_q ? CTRL_GO : CTRL_IDLE;
  assign ctrl.init    = init_q    ? CTRL_GO : CTRL_IDLE;
  assign ctrl.finish  = finish_q  ? CTRL_GO : CTRL_IDLE;
  assign pass_idx_o   = pass_idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

  // Only bit 0 of the controller status carries meaning.
  assign unused_status = ^ctrl.status[31:1];

endmodule
